// File: rtl/iz_param_pkg.sv
// Shared definitions for the neuron parameter load link.
// Frame layout is common to serializer and loader.
package iz_param_pkg;

  localparam int PARAM_W    = 8;
  localparam int NUM_PARAMS = 4;
  localparam int FRAME_BITS = PARAM_W * NUM_PARAMS;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT_ACK,
    DONE
  } state_e;

  // Frame order: a occupies the top byte and goes out first, MSB first.
  function automatic logic [FRAME_BITS-1:0] pack_frame(
    input logic [PARAM_W-1:0] a,
    input logic [PARAM_W-1:0] b,
    input logic [PARAM_W-1:0] c,
    input logic [PARAM_W-1:0] d
  );
    return {a, b, c, d};
  endfunction

endpackage

// File: rtl/iz_bit_timer.sv
// Serial bit period divider.
// Emits a one-cycle tick on the last enabled cycle of each bit.
module iz_bit_timer #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_q, div_d;

  // Divider count: clear wins, otherwise wrap at the bit boundary.
  always_comb begin
    div_d = div_q;
    if (clr_i)
      div_d = '0;
    else if (en_i)
      div_d = (div_q == LAST) ? '0 : div_q + 8'd1;
  end

  // Divider register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= div_d;
  end

  assign tick_o = en_i && !clr_i && (div_q == LAST);

endmodule

// File: rtl/iz_param_serializer.sv
// Transmit end of the neuron parameter load link.
// Shifts {a,b,c,d} out MSB first, then waits for params_ready.
module iz_param_serializer
  import iz_param_pkg::*;
#(
  parameter int CLK_DIV     = 1,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               start,
  input  logic [PARAM_W-1:0] param_a,
  input  logic [PARAM_W-1:0] param_b,
  input  logic [PARAM_W-1:0] param_c,
  input  logic [PARAM_W-1:0] param_d,
  input  logic               params_ready_in,
  output logic               serial_data_out,
  output logic               load_enable_out,
  output logic               busy,
  output logic               done,
  output logic               ack_error
);

  localparam logic [15:0] TO_LAST  = 16'(ACK_TIMEOUT - 1);
  localparam logic [4:0]  BIT_LAST = 5'(FRAME_BITS - 1);

  state_e                  state_q, state_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic [4:0]              bit_q, bit_d;
  logic [15:0]             to_q, to_d;
  logic                    err_q, err_d;
  logic                    accept;
  logic                    tick;
  logic                    to_hit;

  assign accept = enable && start && (state_q == IDLE);
  assign to_hit = (to_q == TO_LAST);

  iz_bit_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (enable && (state_q == SHIFT)),
    .clr_i (accept),
    .tick_o(tick)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      to_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      to_q    <= to_d;
      err_q   <= err_d;
    end
  end

  // Next state; DONE always returns to IDLE so done stays one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (accept) state_d = SHIFT;
      SHIFT:    if (tick && bit_q == BIT_LAST)
                  state_d = WAIT_ACK;
      WAIT_ACK: if (enable && (params_ready_in || to_hit))
                  state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Shift register, bit/timeout counters and sticky error.
  always_comb begin
    shreg_d = shreg_q;
    bit_d   = bit_q;
    to_d    = to_q;
    err_d   = err_q;
    unique case (1'b1)
      accept: begin
        shreg_d = pack_frame(param_a, param_b,
                             param_c, param_d);
        bit_d   = '0;
        err_d   = 1'b0;
      end
      (state_q == SHIFT) && tick: begin
        shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
        if (bit_q == BIT_LAST) to_d  = '0;
        else                   bit_d = bit_q + 5'd1;
      end
      (state_q == WAIT_ACK) && enable
        && !params_ready_in: begin
        if (to_hit) err_d = 1'b1;
        else        to_d  = to_q + 16'd1;
      end
      default: ;
    endcase
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    serial_data_out = (state_q == SHIFT) && shreg_q[FRAME_BITS-1];
    load_enable_out = (state_q == SHIFT);
    busy            = (state_q != IDLE);
    done            = (state_q == DONE);
    ack_error       = err_q;
  end

endmodule

// File: doc/iz_param_serializer.md
Name: iz_param_serializer

Overview:
- Transmit end of the neuron parameter load link.
- Takes four 8-bit Izhikevich parameters (a, b, c, d) and shifts them out serially as one 32-bit frame, MSB first, in the order a, b, c, d.
- Drives the serial data and load-mode pins consumed by the on-chip parameter loader.
- Waits for the loader's params_ready acknowledge and reports completion or timeout to the host-side controller.

Parameters:
CLK_DIV, 1, clock cycles per serial bit (legal 1..255); each bit is held on serial_data_out for CLK_DIV enabled cycles.
ACK_TIMEOUT, 64, enabled cycles to wait for params_ready_in after the last bit before flagging an error (legal 1..65535).

Ports:
clk  input  1  system clock, all logic rising-edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
enable  input  1  global enable; when 0, all counters and state freeze and outputs hold
start  input  1  request to send a frame; sampled only in IDLE
param_a  input  8  parameter a, latched on accepted start
param_b  input  8  parameter b, latched on accepted start
param_c  input  8  parameter c, latched on accepted start
param_d  input  8  parameter d, latched on accepted start
params_ready_in  input  1  acknowledge from the loader, synchronous to clk
serial_data_out  output  1  serial bit stream to the loader
load_enable_out  output  1  load-mode strobe; high exactly while frame bits are valid
busy  output  1  high from the accepted start until the return to IDLE
done  output  1  one-cycle pulse when the transaction ends (ack or timeout)
ack_error  output  1  sticky flag: the last transaction timed out; cleared on the next accepted start

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; shift register, bit counter, divider and timeout counter cleared. Reset mid-frame aborts the frame immediately; load_enable_out drops with no partial-frame completion and no done pulse.
- IDLE: load_enable_out=0, serial_data_out=0, busy=0.
  - On a clock edge with enable=1 and start=1: latch shreg={a,b,c,d}, clear ack_error, bit_cnt=0, div_cnt=0, then go to SHIFT.
  - start while not IDLE is ignored.
- SHIFT: load_enable_out=1, busy=1, serial_data_out=shreg[31] (registered). The first bit appears the cycle after start is accepted.
  - Each enabled cycle increments div_cnt. When div_cnt reaches CLK_DIV-1: div_cnt=0, shreg shifts left by 1, bit_cnt increments.
  - After bit 31 completes its CLK_DIV cycles: go to WAIT_ACK and clear the timeout counter.
  - With CLK_DIV=1 the frame occupies exactly 32 consecutive enabled cycles.
- WAIT_ACK: load_enable_out=0, serial_data_out=0, busy=1.
  - If params_ready_in=1 is sampled (including the first WAIT_ACK cycle): go to DONE, ack_error stays 0.
  - Otherwise increment the counter each enabled cycle. After ACK_TIMEOUT cycles without an ack: set ack_error=1 and go to DONE.
  - If the ack and the timeout occur on the same cycle, the ack wins.
- DONE: done=1 for exactly one cycle, busy=1, then go to IDLE.
  - done is not gated by enable once asserted; it still lasts a single cycle.
- enable=0: no state or counter advance; serial_data_out and load_enable_out hold their current values; start is not accepted.
- params_ready_in high outside WAIT_ACK is ignored.
- Width rules:
  - bit_cnt is 5 bits and saturates logic at 31 (no wrap).
  - div_cnt is 8 bits.
  - The timeout counter is 16 bits; comparison uses ACK_TIMEOUT-1.
- Parameter values are sampled only at start; changes mid-frame have no effect.

Decomposition:
- Shared package iz_param_pkg:
  - PARAM_W=8, NUM_PARAMS=4, FRAME_BITS=32.
  - State enum {IDLE, SHIFT, WAIT_ACK, DONE}.
  - Frame order constant (a first, MSB first), shared with the loader.
- One natural sub-module: iz_bit_timer, the CLK_DIV divider producing a one-cycle bit_tick, with enable and clear inputs.

Test Plan:
1. CLK_DIV=1; a=0xA5, b=0x3C, c=0x81, d=0x7E; pulse start -> load_enable_out high for exactly 32 cycles; serial stream is A53C817E MSB first; params_ready_in asserted 3 cycles later -> done pulse, ack_error=0, busy low the next cycle.
2. CLK_DIV=4, a=0x80, b=c=d=0 -> load_enable_out high for 128 cycles; serial_data_out=1 for the first 4 cycles only.
3. No ack, ACK_TIMEOUT=64 -> done 64 cycles after the frame ends, ack_error=1; the next start clears ack_error.
4. enable dropped for 10 cycles at bit 12 -> the frame stretches to 42 cycles; the bit sequence is unchanged; outputs hold during the gap.
5. reset=0 asserted at bit 20 -> all outputs 0 immediately, no done pulse; a new start after release sends a complete fresh frame.
6. start pulsed during SHIFT and during WAIT_ACK with different param values -> ignored; the frame contents equal the originally latched values.
